// File: rtl/dmarb_pkg.sv
// Shared definitions for the data memory arbiter: FSM state encoding and a
// constant-evaluable ceiling-log2 used to size the burst and starvation counters.
package dmarb_pkg;

  // Pipeline owns the memory by default; S_DMA marks a locked D burst.
  typedef enum logic {
    S_PIPE = 1'b0,
    S_DMA  = 1'b1
  } state_e;

  // Bits needed to hold values 0..value-1 (never less than 1).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return (result == 0) ? 1 : result;
  endfunction

endpackage

// File: rtl/dmarb_starve_ctr.sv
// Saturating starvation counter for requester D. Counts consecutive refused
// cycles, clears on a grant or an idle D, and flags when the limit is reached.
module dmarb_starve_ctr
  import dmarb_pkg::*;
#(
  parameter int unsigned LIMIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam int unsigned   CW      = clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise increment up to the limit and hold there.
  always_comb begin
    // NOTE: default assignment first so no path through the block infers a latch.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = (cnt_q == LIMIT_C);

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates the single-port data memory between the pipeline memory stage (P)
// and a DMA/loader/debug master (D). P has priority; a starved D is forced a
// grant and then holds the memory for a locked burst of at most MAX_BURST beats.
// Optional: define DMARB_STATS_EN to add a saturating stall-cycle counter output.
module data_mem_arbiter
  import dmarb_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned MAX_BURST    = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic             DMARB_CLK,
  input  logic             DMARB_RST,
  input  logic             DMARB_PReq,
  input  logic             DMARB_PWrite,
  input  logic [WIDTH-1:0] DMARB_PAddr,
  input  logic [WIDTH-1:0] DMARB_PWData,
  output logic             DMARB_Stall,
  input  logic             DMARB_DValid,
  input  logic             DMARB_DWrite,
  input  logic             DMARB_DLast,
  input  logic [WIDTH-1:0] DMARB_DAddr,
  input  logic [WIDTH-1:0] DMARB_DWData,
  output logic             DMARB_DReady,
  output logic [WIDTH-1:0] DMARB_DRData,
  output logic             DMARB_DRValid,
  output logic [WIDTH-1:0] DMARB_MemA,
  output logic [WIDTH-1:0] DMARB_MemWD,
  output logic             DMARB_MemWE,
  input  logic [WIDTH-1:0] DMARB_MemRD
`ifdef DMARB_STATS_EN
  ,
  output logic [31:0]      DMARB_StallCnt
`endif
);

  localparam int unsigned        BURST_W     = clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0] MAX_BURST_C = BURST_W'(MAX_BURST);

  state_e             state_q;
  state_e             state_d;
  logic [BURST_W-1:0] burst_cnt_q;
  logic [BURST_W-1:0] burst_cnt_d;
  logic               drvalid_q;
  logic               drvalid_d;
  logic [WIDTH-1:0]   drdata_q;
  logic [WIDTH-1:0]   drdata_d;
  logic               starve_hit;
  logic               grant_d;
  logic               grant_p;

  dmarb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk   (DMARB_CLK),
    .rst_n (DMARB_RST),
    .clr   (grant_d | ~DMARB_DValid),
    .inc   (DMARB_DValid & ~grant_d),
    .hit   (starve_hit)
  );

  // Grant decision and burst bookkeeping from the current state and requests.
  always_comb begin
    grant_d     = 1'b0;
    grant_p     = 1'b0;
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      S_PIPE: begin
        grant_d = DMARB_DValid & (~DMARB_PReq | starve_hit);
        grant_p = DMARB_PReq & ~grant_d;
        if (grant_d && !(DMARB_DLast || (MAX_BURST == 32'd1))) begin
          state_d     = S_DMA;
          burst_cnt_d = BURST_W'(1);
        end
      end
      S_DMA: begin
        grant_d = DMARB_DValid;
        // An idle D, its last beat, or the burst cap all release ownership.
        if (!grant_d || DMARB_DLast || ((burst_cnt_q + 1'b1) == MAX_BURST_C)) begin
          state_d     = S_PIPE;
          burst_cnt_d = '0;
        end else begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_PIPE;
      end
    endcase
    // While reset is held nobody owns the memory, so no write can slip out.
    if (!DMARB_RST) begin
      grant_d = 1'b0;
      grant_p = 1'b0;
    end
  end

  // Memory port mux, handshake outputs and next value of the D read return.
  always_comb begin
    if (grant_d) begin
      DMARB_MemA  = DMARB_DAddr;
      DMARB_MemWD = DMARB_DWData;
      DMARB_MemWE = DMARB_DWrite;
    end else begin
      DMARB_MemA  = DMARB_PAddr;
      DMARB_MemWD = DMARB_PWData;
      DMARB_MemWE = grant_p & DMARB_PWrite;
    end
    DMARB_DReady = grant_d;
    DMARB_Stall  = DMARB_PReq & ~grant_p;
    drvalid_d    = grant_d & ~DMARB_DWrite;
    drdata_d     = drvalid_d ? DMARB_MemRD : drdata_q;
  end

  // Arbiter FSM with its registered read-return outputs.
  always_ff @(posedge DMARB_CLK or negedge DMARB_RST) begin
    if (!DMARB_RST) begin
      state_q     <= S_PIPE;
      burst_cnt_q <= '0;
      drvalid_q   <= 1'b0;
      drdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      drvalid_q   <= drvalid_d;
      drdata_q    <= drdata_d;
    end
  end

  assign DMARB_DRValid = drvalid_q;
  assign DMARB_DRData  = drdata_q;

`ifdef DMARB_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  // Stall-cycle counter, saturating at all ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (DMARB_Stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall-cycle counter register.
  always_ff @(posedge DMARB_CLK or negedge DMARB_RST) begin
    if (!DMARB_RST) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign DMARB_StallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter. Expected D beats and D read returns
// are queued when stimulus is issued; a negedge monitor pops and compares them
// whenever the DUT accepts a beat or presents read data. Cycle-level flags are
// compared directly by the stimulus thread.
module tb_data_mem_arbiter;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] addr;
    logic         we;
    logic [W-1:0] wd;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         p_req, p_write;
  logic [W-1:0] p_addr, p_wdata;
  logic         stall;
  logic         d_valid, d_write, d_last;
  logic [W-1:0] d_addr, d_wdata;
  logic         d_ready;
  logic [W-1:0] d_rdata;
  logic         d_rvalid;
  logic [W-1:0] mem_a, mem_wd, mem_rd;
  logic         mem_we;
`ifdef DMARB_STATS_EN
  logic [31:0]  stall_cnt;
`endif

  logic [W-1:0] mem [256];
  beat_t        exp_beats[$];
  logic [W-1:0] exp_rd[$];
  int           vectors = 0;
  int           miscompares = 0;

  data_mem_arbiter dut (
    .DMARB_CLK     (clk),
    .DMARB_RST     (rst_n),
    .DMARB_PReq    (p_req),
    .DMARB_PWrite  (p_write),
    .DMARB_PAddr   (p_addr),
    .DMARB_PWData  (p_wdata),
    .DMARB_Stall   (stall),
    .DMARB_DValid  (d_valid),
    .DMARB_DWrite  (d_write),
    .DMARB_DLast   (d_last),
    .DMARB_DAddr   (d_addr),
    .DMARB_DWData  (d_wdata),
    .DMARB_DReady  (d_ready),
    .DMARB_DRData  (d_rdata),
    .DMARB_DRValid (d_rvalid),
    .DMARB_MemA    (mem_a),
    .DMARB_MemWD   (mem_wd),
    .DMARB_MemWE   (mem_we),
    .DMARB_MemRD   (mem_rd)
`ifdef DMARB_STATS_EN
    ,
    .DMARB_StallCnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Word-addressed data memory model: combinational read, clocked write.
  assign mem_rd = mem[mem_a[9:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_a[9:2]] <= mem_wd;
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare accepted D beats and D read returns against the queues.
  always @(negedge clk) begin
    if (rst_n && d_ready) begin
      if (exp_beats.size() == 0) begin
        check("unexpected_d_beat", W'(d_ready), '0);
      end else begin
        beat_t b;
        b = exp_beats.pop_front();
        check("d_beat_addr", mem_a, b.addr);
        check("d_beat_we", W'(mem_we), W'(b.we));
        check("d_beat_wd", mem_wd, b.wd);
      end
    end
    if (d_rvalid) begin
      if (exp_rd.size() == 0) begin
        check("unexpected_d_rvalid", W'(d_rvalid), '0);
      end else begin
        logic [W-1:0] e;
        e = exp_rd.pop_front();
        check("d_rdata", d_rdata, e);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    p_req   = 1'b0; p_write = 1'b0; p_addr  = '0; p_wdata = '0;
    d_valid = 1'b0; d_write = 1'b0; d_last  = 1'b0; d_addr = '0; d_wdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);

    // 1. Reset then idle.
    @(negedge clk);
    check("rst_drvalid", W'(d_rvalid), '0);
    check("rst_drdata", d_rdata, '0);
    rst_n = 1'b1;
    next_cycle();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("idle_memwe", W'(mem_we), '0);
      check("idle_stall", W'(stall), '0);
      check("idle_dready", W'(d_ready), '0);
      check("idle_drvalid", W'(d_rvalid), '0);
      next_cycle();
    end
`ifdef DMARB_STATS_EN
    check("idle_stallcnt", stall_cnt, '0);
`endif

    // 2. P-only write then read back.
    p_req = 1'b1; p_write = 1'b1; p_addr = 32'h10; p_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("p_wr_memwe", W'(mem_we), W'(1));
    check("p_wr_mema", mem_a, 32'h10);
    check("p_wr_memwd", mem_wd, 32'hDEAD_BEEF);
    check("p_wr_stall", W'(stall), '0);
    next_cycle();
    p_write = 1'b0;
    @(negedge clk);
    check("p_rd_memwe", W'(mem_we), '0);
    check("p_rd_memrd", mem_rd, 32'hDEAD_BEEF);
    check("p_rd_stall", W'(stall), '0);
    next_cycle();
    idle_inputs();
    next_cycle();

    // 3. D burst into idle slot; P arrives at beat 2 and stalls to the end.
    for (int i = 0; i < 4; i++)
      exp_beats.push_back('{addr: 32'h100 + 32'(4 * i), we: 1'b1, wd: 32'hA000_0000 + 32'(i)});
    for (int i = 0; i < 4; i++) begin
      d_valid = 1'b1; d_write = 1'b1; d_last = (i == 3);
      d_addr  = 32'h100 + 32'(4 * i); d_wdata = 32'hA000_0000 + 32'(i);
      p_req   = (i >= 1); p_write = 1'b0; p_addr = 32'h40;
      @(negedge clk);
      check("burst_dready", W'(d_ready), W'(1));
      check("burst_stall", W'(stall), W'(i >= 1));
      next_cycle();
    end
    // Back in S_PIPE: an unstarved D must now lose to P.
    d_valid = 1'b1; d_write = 1'b0; d_last = 1'b1; d_addr = 32'h180;
    @(negedge clk);
    check("post_burst_dready", W'(d_ready), '0);
    check("post_burst_stall", W'(stall), '0);
    check("post_burst_mema", mem_a, 32'h40);
    next_cycle();
    idle_inputs();
    next_cycle();

    // 4. Starvation: D read wins on cycle 9, data returns on cycle 10.
    mem[8] = 32'h1234_5678;
    exp_beats.push_back('{addr: 32'h20, we: 1'b0, wd: 32'h0});
    exp_rd.push_back(32'h1234_5678);
    p_req = 1'b1; p_write = 1'b0; p_addr = 32'h30;
    d_valid = 1'b1; d_write = 1'b0; d_last = 1'b1; d_addr = 32'h20; d_wdata = '0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check("starve_dready", W'(d_ready), W'(c == 9));
      check("starve_stall", W'(stall), W'(c == 9));
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    check("starve_drvalid", W'(d_rvalid), W'(1));
    next_cycle();
    @(negedge clk);
    check("starve_drvalid_pulse", W'(d_rvalid), '0);
    next_cycle();

    // 5. Burst cap: starved D gets exactly MAX_BURST beats, then P runs.
    for (int i = 0; i < 4; i++)
      exp_beats.push_back('{addr: 32'h200 + 32'(4 * i), we: 1'b1, wd: 32'hB0 + 32'(i)});
    k = 0;
    for (int c = 1; c <= 14; c++) begin
      p_req = 1'b1; p_write = 1'b1; p_addr = 32'h300; p_wdata = 32'h55;
      d_valid = 1'b1; d_write = 1'b1; d_last = 1'b0;
      d_addr = 32'h200 + 32'(4 * k); d_wdata = 32'hB0 + 32'(k);
      @(negedge clk);
      check("cap_dready", W'(d_ready), W'(c >= 9 && c <= 12));
      check("cap_stall", W'(stall), W'(c >= 9 && c <= 12));
      if (d_ready) k++;
      next_cycle();
    end
    check("cap_beats", W'(k), W'(4));
    idle_inputs();
    next_cycle();

    // 6. Reset asserted during beat 2 of a 4-beat write.
    exp_beats.push_back('{addr: 32'h400, we: 1'b1, wd: 32'hC0});
    d_valid = 1'b1; d_write = 1'b1; d_last = 1'b0; d_addr = 32'h400; d_wdata = 32'hC0;
    @(negedge clk);
    check("rstburst_beat1", W'(d_ready), W'(1));
    next_cycle();
    d_addr = 32'h404; d_wdata = 32'hC1;
    rst_n = 1'b0;
    #1;
    check("rstburst_memwe", W'(mem_we), '0);
    check("rstburst_dready", W'(d_ready), '0);
    check("rstburst_drvalid", W'(d_rvalid), '0);
    next_cycle();
    @(negedge clk);
    check("rstburst_memwe_held", W'(mem_we), '0);
    idle_inputs();
    rst_n = 1'b1;
    next_cycle();
    p_req = 1'b1; p_addr = 32'h44;
    d_valid = 1'b1; d_write = 1'b1; d_addr = 32'h408;
    @(negedge clk);
    check("rstburst_pipe_dready", W'(d_ready), '0);
    check("rstburst_pipe_stall", W'(stall), '0);
    next_cycle();
    idle_inputs();
    repeat (2) next_cycle();

    check("beats_drained", W'(exp_beats.size()), '0);
    check("reads_drained", W'(exp_rd.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
